// File: rtl/ex_mem_stage_pkg.sv
// Shared pipeline types for the EX/MEM register:
// datapath widths and the mem/wb control bundle.
package ex_mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } mem_wb_ctl_t;

  localparam mem_wb_ctl_t CTL_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register;
// master is the driver of EX values, slave is the stage itself.
interface ex_mem_stage_if #(
  parameter int DATA_W = ex_mem_stage_pkg::DATA_W,
  parameter int REG_AW = ex_mem_stage_pkg::REG_AW
);
  logic              in_valid;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] store_data;
  logic [REG_AW-1:0] dest_reg;
  logic              ctl_reg_write;
  logic              ctl_mem_to_reg;
  logic              ctl_mem_read;
  logic              ctl_mem_write;
  logic              ctl_branch;
  logic              ctl_branch_ne;

  logic              out_valid;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_AW-1:0] out_dest_reg;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic              out_mem_read;
  logic              out_mem_write;
  logic [DATA_W-1:0] out_branch_target;
  logic              out_pc_src;
  logic              out_fwd_en;

  modport master (
    output in_valid, alu_result, alu_zero, pc_plus4,
    output imm_sext, store_data, dest_reg,
    output ctl_reg_write, ctl_mem_to_reg,
    output ctl_mem_read, ctl_mem_write,
    output ctl_branch, ctl_branch_ne,
    input  out_valid, out_alu_result, out_store_data,
    input  out_dest_reg, out_reg_write, out_mem_to_reg,
    input  out_mem_read, out_mem_write,
    input  out_branch_target, out_pc_src, out_fwd_en
  );

  modport slave (
    input  in_valid, alu_result, alu_zero, pc_plus4,
    input  imm_sext, store_data, dest_reg,
    input  ctl_reg_write, ctl_mem_to_reg,
    input  ctl_mem_read, ctl_mem_write,
    input  ctl_branch, ctl_branch_ne,
    output out_valid, out_alu_result, out_store_data,
    output out_dest_reg, out_reg_write, out_mem_to_reg,
    output out_mem_read, out_mem_write,
    output out_branch_target, out_pc_src, out_fwd_en
  );
endinterface

// File: rtl/ex_mem_stage_branch_resolve.sv
// Branch target adder and BEQ/BNE taken decision,
// evaluated on EX-stage values ahead of the EX/MEM register.
module branch_resolve
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = ex_mem_stage_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] imm_sext,
  input  logic              alu_zero,
  input  logic              ctl_branch,
  input  logic              ctl_branch_ne,
  input  logic              in_valid,
  output logic [DATA_W-1:0] target,
  output logic              taken
);

  // Word offset; carry-out is dropped so the PC wraps silently.
  assign target = pc_plus4 + {imm_sext[DATA_W-3:0], 2'b00};

  assign taken = in_valid & ctl_branch &
                 (alu_zero ^ ctl_branch_ne);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and mem/wb
// control, resolves branches, supports stall and flush.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W = ex_mem_stage_pkg::DATA_W,
  parameter int REG_AW = ex_mem_stage_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  ex_mem_stage_if.slave        bus
);

  logic [DATA_W-1:0] br_target;
  logic              br_taken;
  mem_wb_ctl_t       ctl_in;

  logic              valid_q;
  mem_wb_ctl_t       ctl_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] store_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] target_q;
  logic              taken_q;

  branch_resolve #(.DATA_W(DATA_W)) u_br (
    .pc_plus4      (bus.pc_plus4),
    .imm_sext      (bus.imm_sext),
    .alu_zero      (bus.alu_zero),
    .ctl_branch    (bus.ctl_branch),
    .ctl_branch_ne (bus.ctl_branch_ne),
    .in_valid      (bus.in_valid),
    .target        (br_target),
    .taken         (br_taken)
  );

  // Gate control at the input so a bubble can never store.
  always_comb begin
    ctl_in = CTL_BUBBLE;
    if (bus.in_valid) begin
      ctl_in.reg_write  = bus.ctl_reg_write;
      ctl_in.mem_to_reg = bus.ctl_mem_to_reg;
      ctl_in.mem_read   = bus.ctl_mem_read;
      ctl_in.mem_write  = bus.ctl_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !bus.in_valid)) begin
      valid_q  <= 1'b0;
      ctl_q    <= CTL_BUBBLE;
      alu_q    <= '0;
      store_q  <= '0;
      dest_q   <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
    end else if (!stall) begin
      valid_q  <= 1'b1;
      ctl_q    <= ctl_in;
      alu_q    <= bus.alu_result;
      store_q  <= bus.store_data;
      dest_q   <= bus.dest_reg;
      target_q <= br_target;
      taken_q  <= br_taken;
    end
  end

  assign bus.out_valid         = valid_q;
  assign bus.out_alu_result    = alu_q;
  assign bus.out_store_data    = store_q;
  assign bus.out_dest_reg      = dest_q;
  assign bus.out_reg_write     = ctl_q.reg_write;
  assign bus.out_mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.out_mem_read      = ctl_q.mem_read;
  assign bus.out_mem_write     = ctl_q.mem_write;
  assign bus.out_branch_target = target_q;
  assign bus.out_pc_src        = taken_q;
  assign bus.out_fwd_en        = valid_q & ctl_q.reg_write &
                                 (|dest_q);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, branches, stall,
// flush priority, bubbles, r0 forwarding and target wrap.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst, stall, flush;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.in_valid       = 1'b0;
    bus.alu_result     = '0;
    bus.alu_zero       = 1'b0;
    bus.pc_plus4       = '0;
    bus.imm_sext       = '0;
    bus.store_data     = '0;
    bus.dest_reg       = '0;
    bus.ctl_reg_write  = 1'b0;
    bus.ctl_mem_to_reg = 1'b0;
    bus.ctl_mem_read   = 1'b0;
    bus.ctl_mem_write  = 1'b0;
    bus.ctl_branch     = 1'b0;
    bus.ctl_branch_ne  = 1'b0;
  endtask

  task automatic busy_in();
    bus.in_valid       = 1'b1;
    bus.alu_result     = 32'hA5A5_0001;
    bus.alu_zero       = 1'b1;
    bus.pc_plus4       = 32'h0000_1000;
    bus.imm_sext       = 32'h0000_0010;
    bus.store_data     = 32'h1234_5678;
    bus.dest_reg       = 5'd31;
    bus.ctl_reg_write  = 1'b1;
    bus.ctl_mem_to_reg = 1'b1;
    bus.ctl_mem_read   = 1'b1;
    bus.ctl_mem_write  = 1'b1;
    bus.ctl_branch     = 1'b1;
    bus.ctl_branch_ne  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},  32'(bus.out_valid), 32'd0);
    check({tag, ".alu"},    bus.out_alu_result, 32'd0);
    check({tag, ".sd"},     bus.out_store_data, 32'd0);
    check({tag, ".dest"},   32'(bus.out_dest_reg), 32'd0);
    check({tag, ".ctl"},
          {28'd0, bus.out_reg_write, bus.out_mem_to_reg,
           bus.out_mem_read, bus.out_mem_write}, 32'd0);
    check({tag, ".tgt"},    bus.out_branch_target, 32'd0);
    check({tag, ".pcsrc"},  32'(bus.out_pc_src), 32'd0);
    check({tag, ".fwd"},    32'(bus.out_fwd_en), 32'd0);
  endtask

  task automatic branch(input logic [31:0] pc,
                        input logic [31:0] imm,
                        input logic z, input logic ne);
    idle_in();
    bus.in_valid      = 1'b1;
    bus.pc_plus4      = pc;
    bus.imm_sext      = imm;
    bus.alu_zero      = z;
    bus.ctl_branch    = 1'b1;
    bus.ctl_branch_ne = ne;
  endtask

  initial begin
    stall = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    busy_in();
    step();
    step();
    check_zero("rst");

    // 1: first real instruction after reset
    rst = 1'b0;
    idle_in();
    bus.in_valid      = 1'b1;
    bus.alu_result    = 32'h0000_0010;
    bus.dest_reg      = 5'd8;
    bus.ctl_reg_write = 1'b1;
    step();
    check("t1.valid", 32'(bus.out_valid), 32'd1);
    check("t1.alu", bus.out_alu_result, 32'h10);
    check("t1.dest", 32'(bus.out_dest_reg), 32'd8);
    check("t1.rw", 32'(bus.out_reg_write), 32'd1);
    check("t1.fwd", 32'(bus.out_fwd_en), 32'd1);

    // 2: BEQ / BNE decisions, backward target
    branch(32'h0040_0004, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();
    check("beq.tgt", bus.out_branch_target, 32'h003F_FFFC);
    check("beq.taken", 32'(bus.out_pc_src), 32'd1);
    check("beq.fwd", 32'(bus.out_fwd_en), 32'd0);
    branch(32'h0040_0004, 32'hFFFF_FFFE, 1'b0, 1'b0);
    step();
    check("beq.nt", 32'(bus.out_pc_src), 32'd0);
    branch(32'h0040_0004, 32'hFFFF_FFFE, 1'b0, 1'b1);
    step();
    check("bne.taken", 32'(bus.out_pc_src), 32'd1);
    branch(32'h0040_0004, 32'hFFFF_FFFE, 1'b1, 1'b1);
    step();
    check("bne.nt", 32'(bus.out_pc_src), 32'd0);
    branch(32'h0040_0004, 32'hFFFF_FFFE, 1'b1, 1'b0);
    bus.ctl_branch = 1'b0;
    step();
    check("nobr.taken", 32'(bus.out_pc_src), 32'd0);

    // 3: store held across a 3-cycle stall
    idle_in();
    bus.in_valid      = 1'b1;
    bus.alu_result    = 32'h0000_1000;
    bus.store_data    = 32'hDEAD_BEEF;
    bus.ctl_mem_write = 1'b1;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      busy_in();
      bus.alu_result = 32'h7000_0000 + 32'(i);
      bus.in_valid   = i[0];
      step();
      check("stall.alu", bus.out_alu_result, 32'h0000_1000);
      check("stall.sd", bus.out_store_data, 32'hDEAD_BEEF);
      check("stall.mw", 32'(bus.out_mem_write), 32'd1);
      check("stall.rw", 32'(bus.out_reg_write), 32'd0);
      check("stall.valid", 32'(bus.out_valid), 32'd1);
      check("stall.pcsrc", 32'(bus.out_pc_src), 32'd0);
    end

    // held branch decision survives a stall
    stall = 1'b0;
    branch(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0);
    step();
    stall = 1'b1;
    idle_in();
    step();
    check("stallbr.taken", 32'(bus.out_pc_src), 32'd1);
    check("stallbr.tgt", bus.out_branch_target, 32'h104);

    // 4: flush wins over stall
    stall = 1'b0;
    busy_in();
    step();
    check("pre.fwd", 32'(bus.out_fwd_en), 32'd1);
    stall = 1'b1;
    flush = 1'b1;
    step();
    check_zero("flush");
    stall = 1'b0;
    flush = 1'b0;

    // 5: bubble ignores control; r0 blocks forwarding
    idle_in();
    bus.ctl_mem_write = 1'b1;
    bus.alu_result    = 32'h0000_2000;
    step();
    check("bub.mw", 32'(bus.out_mem_write), 32'd0);
    check("bub.valid", 32'(bus.out_valid), 32'd0);
    check("bub.alu", bus.out_alu_result, 32'd0);
    idle_in();
    bus.in_valid      = 1'b1;
    bus.dest_reg      = 5'd0;
    bus.ctl_reg_write = 1'b1;
    bus.alu_result    = 32'h0000_0042;
    step();
    check("r0.rw", 32'(bus.out_reg_write), 32'd1);
    check("r0.fwd", 32'(bus.out_fwd_en), 32'd0);
    check("r0.alu", bus.out_alu_result, 32'h42);

    // 6: target wraps modulo 2^32
    branch(32'hFFFF_FFFC, 32'h0000_0002, 1'b0, 1'b0);
    step();
    check("wrap.tgt", bus.out_branch_target, 32'h0000_0004);
    check("wrap.nt", 32'(bus.out_pc_src), 32'd0);

    // reset during stall and flush
    busy_in();
    step();
    rst   = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    step();
    check_zero("rstmid");
    rst   = 1'b0;
    flush = 1'b0;
    step();
    check_zero("rsthold");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
